data_unit_p: RTL and testbench

Parametrised next-generation data unit for YASAC.
- Holds PC, IR, register file, MAR, MDR, status register and stack pointer; routes them over the internal bus.
- Data memory and code memory are external. Data memory is reached through a REQ/ACK handshake with arbitrary wait states.
- The ALU is external. It is fed REG_A and the B-operand mux, and returns a result plus status.
- The control unit drives the strobes and watches MEM_BUSY before sequencing the next step.

---
 rtl/data_unit_p_if.sv | 24 ++
 rtl/data_unit_p.sv | 218 +++++++++++++++++++++
 tb/tb_data_unit_p.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_unit_p_if.sv
// Data-memory handshake bundle for the YASAC data unit: REQ/ACK with a write
// qualifier, address and both data directions.
`timescale 1ns/1ps
interface data_unit_p_if #(
  parameter int DW = 8,
  parameter int AW = 8
) ();
  logic          MEM_REQ;
  logic          MEM_WR;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WR, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WR, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/data_unit_p.sv
// YASAC data unit: PC, IR, register file, MAR/MDR, status, stack pointer, internal
// bus and a data-memory handshake FSM. Optional define YASAC_SP_GUARD_EN.
`timescale 1ns/1ps
module data_unit_p #(
  parameter int            DW     = 8,
  parameter int            AW     = 8,
  parameter int            NREG   = 8,
  parameter logic [AW-1:0] RAMEND = {AW{1'b1}},
  localparam int           SW     = $clog2(NREG),
  localparam int           IW     = 5 + SW + DW
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  input  logic [DW-1:0] ALU_R,
  input  logic [7:0]    ALU_ST,
  input  logic          INC_PROGCOUNT,
  input  logic          CLR_PROGCOUNT,
  input  logic          WRITE_PROGCOUNT,
  input  logic          READ_PROGCOUNT,
  input  logic          WRITE_INSTREG,
  input  logic          WRITE_REGS,
  input  logic          USE_IMMEDIATE,
  input  logic          WRITE_MEMADDR,
  input  logic          MEM_START,
  input  logic          MEM_WE,
  input  logic          READ_MEM,
  input  logic          WRITE_STATREG,
  input  logic          CLR_STATBIT,
  input  logic          SET_STATBIT,
  input  logic          PRESET_STACKPTR,
  input  logic          INC_STACKPTR,
  input  logic          DEC_STACKPTR,
  input  logic          READ_STACKPTR,
  output logic [AW-1:0] CODE_ADDR,
  input  logic [IW-1:0] CODE_DATA,
  data_unit_p_if.master mem,
  output logic          MEM_BUSY,
  output logic [4:0]    OPCODE,
  output logic [2:0]    STATUS_SEL,
  output logic [7:0]    STATUS,
  output logic          SP_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]    stat_q, stat_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  logic [DW-1:0] bus;
  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic [2:0]    stat_sel;
  logic [DW-1:0] imm;

  // SEL_A and STATUS_SEL share the field right below the opcode.
  assign sel_a    = ir_q[IW-6 -: SW];
  assign sel_b    = ir_q[SW-1:0];
  assign stat_sel = ir_q[IW-6 -: 3];
  assign imm      = ir_q[DW-1:0];

  assign ALU_A      = regs_q[sel_a];
  assign ALU_B      = USE_IMMEDIATE ? imm : regs_q[sel_b];
  assign CODE_ADDR  = pc_q;
  assign OPCODE     = ir_q[IW-1 -: 5];
  assign STATUS_SEL = stat_sel;
  assign STATUS     = stat_q;
  assign MEM_BUSY   = (state_q != ST_IDLE);

  assign mem.MEM_REQ   = mem_req_q;
  assign mem.MEM_WR    = mem_wr_q;
  assign mem.MEM_ADDR  = mem_addr_q;
  assign mem.MEM_WDATA = mem_wdata_q;

  // Address-wide sources are zero-extended or truncated onto the data-wide bus.
  always_comb begin
    bus = ALU_R;
    if (READ_MEM)            bus = mdr_q;
    else if (READ_STACKPTR)  bus = DW'(sp_q);
    else if (READ_PROGCOUNT) bus = DW'(pc_q);
  end

  always_comb begin
    pc_d = pc_q;
    if (CLR_PROGCOUNT)        pc_d = '0;
    else if (INC_PROGCOUNT)   pc_d = pc_q + AW'(1);
    else if (WRITE_PROGCOUNT) pc_d = AW'(bus);
  end

  always_comb begin
    ir_d  = WRITE_INSTREG ? CODE_DATA : ir_q;
    mar_d = WRITE_MEMADDR ? AW'(bus) : mar_q;
  end

  always_comb begin
    regs_d = regs_q;
    if (WRITE_REGS) regs_d[sel_a] = bus;
  end

  always_comb begin
    stat_d = stat_q;
    if (WRITE_STATREG)    stat_d           = ALU_ST;
    else if (CLR_STATBIT) stat_d[stat_sel] = 1'b0;
    else if (SET_STATBIT) stat_d[stat_sel] = 1'b1;
  end

`ifdef YASAC_SP_GUARD_EN
  logic sp_err_q, sp_err_d;

  // Out-of-range moves freeze SP and latch the error until PRESET or reset.
  always_comb begin
    sp_d     = sp_q;
    sp_err_d = sp_err_q;
    if (PRESET_STACKPTR) begin
      sp_d     = RAMEND;
      sp_err_d = 1'b0;
    end else if (INC_STACKPTR) begin
      if (sp_q == RAMEND) sp_err_d = 1'b1;
      else                sp_d     = sp_q + AW'(1);
    end else if (DEC_STACKPTR) begin
      if (sp_q == '0) sp_err_d = 1'b1;
      else            sp_d     = sp_q - AW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) sp_err_q <= 1'b0;
    else     sp_err_q <= sp_err_d;
  end

  assign SP_ERR = sp_err_q;
`else
  always_comb begin
    sp_d = sp_q;
    if (PRESET_STACKPTR)   sp_d = RAMEND;
    else if (INC_STACKPTR) sp_d = sp_q + AW'(1);
    else if (DEC_STACKPTR) sp_d = sp_q - AW'(1);
  end

  assign SP_ERR = 1'b0;
`endif

  // Request and its qualifiers are captured once in IDLE and frozen until ACK.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mdr_d       = mdr_q;
    case (state_q)
      ST_IDLE: begin
        if (MEM_START) begin
          mem_addr_d  = mar_q;
          mem_wr_d    = MEM_WE;
          mem_wdata_d = bus;
          mem_req_d   = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.MEM_ACK) begin
          if (!mem_wr_q) mdr_d = mem.MEM_RDATA;
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      sp_q        <= RAMEND;
      ir_q        <= '0;
      mar_q       <= '0;
      mdr_q       <= '0;
      stat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      ir_q        <= ir_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      stat_q      <= stat_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_data_unit_p.sv
// Directed + randomized bench for data_unit_p against a behavioural model of the
// data unit state (default parameters) plus a wide-parameter spot check.
`timescale 1ns/1ps
module tb_data_unit_p;

`ifdef YASAC_SP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  alu_r, alu_st;
  logic        inc_pc, clr_pc, wr_pc, rd_pc, wr_ir, wr_regs, use_imm, wr_mar;
  logic        mem_start, mem_we, rd_mem, wr_st, clr_sb, set_sb;
  logic        pre_sp, inc_sp, dec_sp, rd_sp;
  logic [15:0] code_data;
  logic [7:0]  alu_a, alu_b, code_addr, status;
  logic [4:0]  opcode;
  logic [2:0]  status_sel;
  logic        mem_busy, sp_err;

  data_unit_p_if #(.DW(8), .AW(8)) mem_if ();

  data_unit_p dut (
    .CLK(clk), .RST(rst), .ALU_A(alu_a), .ALU_B(alu_b), .ALU_R(alu_r), .ALU_ST(alu_st),
    .INC_PROGCOUNT(inc_pc), .CLR_PROGCOUNT(clr_pc), .WRITE_PROGCOUNT(wr_pc),
    .READ_PROGCOUNT(rd_pc), .WRITE_INSTREG(wr_ir), .WRITE_REGS(wr_regs),
    .USE_IMMEDIATE(use_imm), .WRITE_MEMADDR(wr_mar), .MEM_START(mem_start),
    .MEM_WE(mem_we), .READ_MEM(rd_mem), .WRITE_STATREG(wr_st), .CLR_STATBIT(clr_sb),
    .SET_STATBIT(set_sb), .PRESET_STACKPTR(pre_sp), .INC_STACKPTR(inc_sp),
    .DEC_STACKPTR(dec_sp), .READ_STACKPTR(rd_sp), .CODE_ADDR(code_addr),
    .CODE_DATA(code_data), .mem(mem_if.master), .MEM_BUSY(mem_busy), .OPCODE(opcode),
    .STATUS_SEL(status_sel), .STATUS(status), .SP_ERR(sp_err)
  );

  // Wide instance shares the strobes; only exercised in the last section.
  logic [15:0] w_alu_r, w_alu_a, w_alu_b;
  logic [24:0] w_code;
  logic [9:0]  w_code_addr;
  logic [4:0]  w_opcode;
  logic [2:0]  w_ssel;
  logic [7:0]  w_status;
  logic        w_busy, w_sp_err;

  data_unit_p_if #(.DW(16), .AW(10)) wmem_if ();
  assign wmem_if.MEM_ACK   = 1'b0;
  assign wmem_if.MEM_RDATA = '0;

  data_unit_p #(.DW(16), .AW(10), .NREG(16)) dut_w (
    .CLK(clk), .RST(rst), .ALU_A(w_alu_a), .ALU_B(w_alu_b), .ALU_R(w_alu_r), .ALU_ST(alu_st),
    .INC_PROGCOUNT(inc_pc), .CLR_PROGCOUNT(clr_pc), .WRITE_PROGCOUNT(wr_pc),
    .READ_PROGCOUNT(rd_pc), .WRITE_INSTREG(wr_ir), .WRITE_REGS(wr_regs),
    .USE_IMMEDIATE(use_imm), .WRITE_MEMADDR(wr_mar), .MEM_START(mem_start),
    .MEM_WE(mem_we), .READ_MEM(rd_mem), .WRITE_STATREG(wr_st), .CLR_STATBIT(clr_sb),
    .SET_STATBIT(set_sb), .PRESET_STACKPTR(pre_sp), .INC_STACKPTR(inc_sp),
    .DEC_STACKPTR(dec_sp), .READ_STACKPTR(rd_sp), .CODE_ADDR(w_code_addr),
    .CODE_DATA(w_code), .mem(wmem_if.master), .MEM_BUSY(w_busy), .OPCODE(w_opcode),
    .STATUS_SEL(w_ssel), .STATUS(w_status), .SP_ERR(w_sp_err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state of the default-parameter unit.
  logic [7:0]  m_regs [8];
  logic [7:0]  m_pc, m_sp, m_st, m_mar, m_mdr;
  logic [15:0] m_ir;
  logic        m_err;
  logic [7:0]  mem_m [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    {inc_pc, clr_pc, wr_pc, rd_pc, wr_ir, wr_regs, use_imm, wr_mar} = '0;
    {mem_start, mem_we, rd_mem, wr_st, clr_sb, set_sb} = '0;
    {pre_sp, inc_sp, dec_sp, rd_sp} = '0;
    alu_r = '0;
    alu_st = '0;
    mem_if.MEM_ACK = 1'b0;
    mem_if.MEM_RDATA = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_pc = '0; m_sp = 8'hFF; m_st = '0; m_mar = '0; m_mdr = '0; m_ir = '0; m_err = 1'b0;
  endtask

  task automatic load_ir(input logic [15:0] ir);
    code_data = ir;
    wr_ir = 1'b1;
    step();
    wr_ir = 1'b0;
    m_ir = ir;
    check("opcode", opcode, ir[15:11]);
    check("status_sel", status_sel, ir[10:8]);
  endtask

  task automatic check_operands();
    check("alu_a", alu_a, m_regs[m_ir[10:8]]);
    check("alu_b_reg", alu_b, m_regs[m_ir[2:0]]);
    use_imm = 1'b1;
    #1;
    check("alu_b_imm", alu_b, m_ir[7:0]);
    use_imm = 1'b0;
  endtask

  // Drive the bus from the chosen sources into REGS[SEL_A] and read it back on ALU_A.
  task automatic bus_write(input bit rm, input bit rs, input bit rp, input logic [7:0] r);
    logic [7:0] b;
    rd_mem = rm; rd_sp = rs; rd_pc = rp; alu_r = r; wr_regs = 1'b1;
    step();
    {rd_mem, rd_sp, rd_pc, wr_regs} = '0;
    b = rm ? m_mdr : rs ? m_sp : rp ? m_pc : r;
    m_regs[m_ir[10:8]] = b;
    check("bus_to_reg", alu_a, b);
  endtask

  task automatic pc_op(input bit c, input bit i, input bit w, input logic [7:0] r);
    clr_pc = c; inc_pc = i; wr_pc = w; alu_r = r;
    step();
    {clr_pc, inc_pc, wr_pc} = '0;
    if (c) m_pc = 8'h00;
    else if (i) m_pc = m_pc + 8'd1;
    else if (w) m_pc = r;
    check("code_addr", code_addr, m_pc);
  endtask

  task automatic sp_op(input bit p, input bit i, input bit d);
    pre_sp = p; inc_sp = i; dec_sp = d;
    step();
    {pre_sp, inc_sp, dec_sp} = '0;
    if (p) begin
      m_sp = 8'hFF; m_err = 1'b0;
    end else if (i) begin
      if (GUARD && m_sp == 8'hFF) m_err = 1'b1; else m_sp = m_sp + 8'd1;
    end else if (d) begin
      if (GUARD && m_sp == 8'h00) m_err = 1'b1; else m_sp = m_sp - 8'd1;
    end
    check("sp_err", sp_err, m_err);
    bus_write(1'b0, 1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic st_op(input bit w, input bit c, input bit s, input logic [7:0] st);
    wr_st = w; clr_sb = c; set_sb = s; alu_st = st;
    step();
    {wr_st, clr_sb, set_sb} = '0;
    if (w) m_st = st;
    else if (c) m_st[m_ir[10:8]] = 1'b0;
    else if (s) m_st[m_ir[10:8]] = 1'b1;
    check("status", status, m_st);
  endtask

  // Full handshake with the bench acting as memory; reads land in REGS[SEL_A].
  task automatic mem_txn(input bit we, input logic [7:0] addr, input logic [7:0] wd, input int waits);
    logic [7:0] rd;
    alu_r = addr; wr_mar = 1'b1;
    step();
    wr_mar = 1'b0; m_mar = addr;
    mem_start = 1'b1; mem_we = we; alu_r = wd;
    step();
    mem_start = 1'b0; mem_we = 1'b0;
    rd = mem_m[addr];
    for (int k = 0; k <= waits; k++) begin
      check("req_hold", mem_if.MEM_REQ, 1'b1);
      check("wr_hold", mem_if.MEM_WR, we);
      check("addr_hold", mem_if.MEM_ADDR, addr);
      check("wdata_hold", mem_if.MEM_WDATA, wd);
      check("busy_wait", mem_busy, 1'b1);
      alu_r = 8'($urandom);
      mem_start = 1'($urandom_range(0, 1));
      if (k == waits) begin
        mem_if.MEM_ACK = 1'b1;
        mem_if.MEM_RDATA = we ? 8'($urandom) : rd;
      end else begin
        mem_if.MEM_RDATA = 8'($urandom);
        wr_mar = 1'($urandom_range(0, 1));
        if (wr_mar) m_mar = alu_r;
      end
      step();
      wr_mar = 1'b0;
    end
    if (we) mem_m[addr] = wd; else m_mdr = rd;
    check("req_drop", mem_if.MEM_REQ, 1'b0);
    check("busy_done", mem_busy, 1'b1);
    mem_if.MEM_ACK = 1'($urandom_range(0, 1));
    mem_if.MEM_RDATA = 8'($urandom);
    mem_start = 1'($urandom_range(0, 1));
    step();
    mem_if.MEM_ACK = 1'b0;
    mem_start = 1'b0;
    check("busy_idle", mem_busy, 1'b0);
    check("req_idle", mem_if.MEM_REQ, 1'b0);
    $display("txn %s addr=%02h data=%02h waits=%0d", we ? "WR" : "RD", addr, we ? wd : rd, waits);
    if (!we) bus_write(1'b1, 1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    int op;
    clear_ctl();
    code_data = '0; w_code = '0; w_alu_r = '0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'($urandom);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();

    check("rst_req", mem_if.MEM_REQ, 1'b0);
    check("rst_wr", mem_if.MEM_WR, 1'b0);
    check("rst_wdata", mem_if.MEM_WDATA, 8'h00);
    check("rst_busy", mem_busy, 1'b0);
    check("rst_pc", code_addr, 8'h00);
    check("rst_status", status, 8'h00);
    check("rst_sp_err", sp_err, 1'b0);
    check("rst_opcode", opcode, 5'h00);
    check_operands();
    bus_write(1'b0, 1'b1, 1'b0, 8'h00);

    mem_txn(1'b1, 8'h20, 8'h5A, 3);
    load_ir({5'h00, 3'd3, 8'h00});
    mem_m[8'h21] = 8'hC3;
    mem_txn(1'b0, 8'h21, 8'h00, 0);
    check("mdr_to_r3", alu_a, 8'hC3);

    pc_op(1'b0, 1'b0, 1'b1, 8'hFF);
    pc_op(1'b0, 1'b1, 1'b0, 8'h00);
    pc_op(1'b0, 1'b0, 1'b1, 8'h05);
    pc_op(1'b1, 1'b1, 1'b0, 8'h00);
    pc_op(1'b0, 1'b0, 1'b1, 8'h40);
    check("pc_write_40", code_addr, 8'h40);
    pc_op(1'b0, 1'b1, 1'b1, 8'h99);

    sp_op(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) sp_op(1'b0, 1'b0, 1'b1);
    sp_op(1'b0, 1'b0, 1'b1);
    check("sp_dec_zero", alu_a, GUARD ? 8'h00 : 8'hFF);
    check("sp_err_zero", sp_err, GUARD);
    sp_op(1'b1, 1'b0, 1'b0);
    check("sp_err_preset", sp_err, 1'b0);

    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          load_ir(16'($urandom));
          check_operands();
          bus_write(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), 8'($urandom));
          check_operands();
        end
        1: pc_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
        2: sp_op(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        3: st_op(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
        default: mem_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $urandom_range(0, 4));
      endcase
    end

    // Reset in the middle of a transaction, then a stray ACK.
    alu_r = 8'h30; wr_mar = 1'b1;
    step();
    wr_mar = 1'b0;
    mem_start = 1'b1; mem_we = 1'b0;
    step();
    mem_start = 1'b0;
    check("pre_rst_req", mem_if.MEM_REQ, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("rstw_req", mem_if.MEM_REQ, 1'b0);
    check("rstw_busy", mem_busy, 1'b0);
    check("rstw_pc", code_addr, 8'h00);
    check("rstw_status", status, 8'h00);
    mem_if.MEM_ACK = 1'b1; mem_if.MEM_RDATA = 8'hAA;
    step();
    mem_if.MEM_ACK = 1'b0;
    check("late_ack_req", mem_if.MEM_REQ, 1'b0);
    check("late_ack_busy", mem_busy, 1'b0);
    bus_write(1'b1, 1'b0, 1'b0, 8'h77);
    bus_write(1'b0, 1'b1, 1'b0, 8'h00);

    // Wide configuration: DW=16, AW=10, NREG=16.
    rst = 1'b1;
    step();
    rst = 1'b0;
    w_code = {5'h0A, 4'd5, 16'hBEEF};
    wr_ir = 1'b1;
    step();
    wr_ir = 1'b0;
    check("w_opcode", w_opcode, 5'h0A);
    w_alu_r = 16'h03FF; wr_pc = 1'b1;
    step();
    wr_pc = 1'b0;
    check("w_pc", w_code_addr, 10'h3FF);
    rd_pc = 1'b1; wr_regs = 1'b1; w_alu_r = 16'h1234;
    step();
    rd_pc = 1'b0; wr_regs = 1'b0;
    check("w_bus_pc", w_alu_a, 16'h03FF);
    use_imm = 1'b1;
    #1;
    check("w_imm", w_alu_b, 16'hBEEF);
    use_imm = 1'b0;
    inc_pc = 1'b1;
    step();
    inc_pc = 1'b0;
    check("w_pc_wrap", w_code_addr, 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
